// File: rtl/gate_sched_pkg.sv
// Shared types and the bitwise gate evaluator for the gate_op_scheduler block.
package gate_sched_pkg;

  localparam int GATE_OP_W  = 2;
  // Operand width supported by gate_eval; callers cast their W-bit data in and out.
  localparam int GATE_MAX_W = 64;

  typedef enum logic [GATE_OP_W-1:0] {
    GATE_AND  = 2'b00,
    GATE_OR   = 2'b01,
    GATE_XOR  = 2'b10,
    GATE_NAND = 2'b11
  } gate_op_e;

  function automatic logic [GATE_MAX_W-1:0] gate_eval(
    input gate_op_e              op,
    input logic [GATE_MAX_W-1:0] a,
    input logic [GATE_MAX_W-1:0] b
  );
    logic [GATE_MAX_W-1:0] y;
    case (op)
      GATE_AND:  y = a & b;
      GATE_OR:   y = a | b;
      GATE_XOR:  y = a ^ b;
      GATE_NAND: y = ~(a & b);
      default:   y = {GATE_MAX_W{1'b0}};
    endcase
    return y;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps upward.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic found_s;
  int   cand_s;

  // Priority search from ptr+1 with wrap-around; grant only when enabled.
  always_comb begin
    found_s = 1'b0;
    cand_s  = 0;
    idx     = {IW{1'b0}};
    grant   = {N{1'b0}};
    for (int k = 1; k <= N; k++) begin
      cand_s = (int'(ptr) + k) % N;
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        idx     = IW'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
    if (en && found_s) begin
      grant[idx] = 1'b1;
    end else begin
      grant = {N{1'b0}};
    end
  end

endmodule

// File: rtl/gate_op_scheduler.sv
// Shares one registered AND/OR/XOR/NAND unit among N_REQ requesters via round-robin.
// Optional GATE_GRANT_CNT_EN adds a 16-bit wrapping count of accepted transfers.
module gate_op_scheduler
  import gate_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*W-1:0]         req_a,
  input  logic [N_REQ*W-1:0]         req_b,
  input  logic [N_REQ*GATE_OP_W-1:0] req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [W-1:0]               rsp_y
`ifdef GATE_GRANT_CNT_EN
  ,
  output logic [15:0]                grant_cnt
`endif
);

  logic              can_accept_s;
  logic              xfer_s;
  logic [N_REQ-1:0]  grant_s;
  logic [ID_W-1:0]   win_idx_s;
  logic [W-1:0]      a_sel_s;
  logic [W-1:0]      b_sel_s;
  gate_op_e          op_sel_s;
  logic [W-1:0]      y_sel_s;

  logic              rsp_valid_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [W-1:0]      rsp_y_r;
  logic [ID_W-1:0]   rr_ptr_r;

  // Gating with rst_n keeps req_ready low while reset is held.
  assign can_accept_s = !rsp_valid_r || rsp_ready;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .en    (can_accept_s && rst_n),
    .grant (grant_s),
    .idx   (win_idx_s)
  );

  assign xfer_s    = |grant_s;
  assign req_ready = grant_s;

  // Operand mux for the winning lane feeding the shared gate.
  always_comb begin
    a_sel_s  = req_a[int'(win_idx_s)*W +: W];
    b_sel_s  = req_b[int'(win_idx_s)*W +: W];
    op_sel_s = gate_op_e'(req_op[int'(win_idx_s)*GATE_OP_W +: GATE_OP_W]);
    y_sel_s  = W'(gate_eval(op_sel_s, GATE_MAX_W'(a_sel_s), GATE_MAX_W'(b_sel_s)));
  end

  // Single-entry result register; reloads in the drain cycle for full throughput.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= {ID_W{1'b0}};
      rsp_y_r     <= {W{1'b0}};
      rr_ptr_r    <= ID_W'(N_REQ - 1);
    end else if (xfer_s) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= win_idx_s;
      rsp_y_r     <= y_sel_s;
      rr_ptr_r    <= win_idx_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_y     = rsp_y_r;

`ifdef GATE_GRANT_CNT_EN
  logic [15:0] grant_cnt_r;

  // Free-running count of accepted transfers, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_r <= 16'd0;
    end else if (xfer_s) begin
      grant_cnt_r <= grant_cnt_r + 16'd1;
    end else begin
      grant_cnt_r <= grant_cnt_r;
    end
  end

  assign grant_cnt = grant_cnt_r;
`endif

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Directed self-checking bench for gate_op_scheduler (N_REQ=4, W=8).
module tb_gate_op_scheduler;

  localparam int N_REQ = 4;
  localparam int W     = 8;
  localparam int ID_W  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ*2-1:0] req_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [W-1:0]     rsp_y;
`ifdef GATE_GRANT_CNT_EN
  logic [15:0]      grant_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_fair [4] = '{8'h05, 8'hAF, 8'hAA, 8'hFA};
  logic [7:0] exp_op   [4] = '{8'h30, 8'hFC, 8'hCC, 8'hCF};

  always #5 clk = ~clk;

  gate_op_scheduler #(.N_REQ(N_REQ), .W(W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y)
`ifdef GATE_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
    req_op[i*2 +: 2] = op;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    for (int i = 0; i < N_REQ; i++) set_lane(i, 8'hA5, 8'h0F, 2'(i));

    // Reset held with every requester asking
    #23;
    check_val("rst_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_y",     32'(rsp_y),     32'd0);
    check_val("rst_id",    32'(rsp_id),    32'd0);
`ifdef GATE_GRANT_CNT_EN
    check_val("rst_cnt",   32'(grant_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check_val("first_grant", 32'(req_ready), 32'b0001);

    // Fairness: all valid, full throughput
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val("fair_valid", 32'(rsp_valid), 32'd1);
      check_val("fair_id",    32'(rsp_id),    32'(k % 4));
      check_val("fair_y",     32'(rsp_y),     32'(exp_fair[k % 4]));
    end

    // Backpressure while FULL
    rsp_ready = 1'b0;
    #1;
    check_val("bp_ready0", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("bp_valid", 32'(rsp_valid), 32'd1);
      check_val("bp_id",    32'(rsp_id),    32'd3);
      check_val("bp_y",     32'(rsp_y),     32'hFA);
      check_val("bp_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check_val("bp_regrant", 32'(req_ready), 32'b0001);
    tick();
    check_val("bp_next_id", 32'(rsp_id), 32'd0);
    check_val("bp_next_y",  32'(rsp_y),  32'h05);
    req_valid = 4'b0000;
    tick();
    check_val("drain_valid", 32'(rsp_valid), 32'd0);
    check_val("drain_y",     32'(rsp_y),     32'h05);
    check_val("drain_id",    32'(rsp_id),    32'd0);

    // Opcode sweep on requester 2
    req_valid = 4'b0100;
    for (int op = 0; op < 4; op++) begin
      set_lane(2, 8'hF0, 8'h3C, 2'(op));
      #1;
      check_val("op_ready", 32'(req_ready), 32'b0100);
      tick();
      check_val("op_y",     32'(rsp_y),     32'(exp_op[op]));
      check_val("op_id",    32'(rsp_id),    32'd2);
      check_val("op_valid", 32'(rsp_valid), 32'd1);
    end
    req_valid = 4'b0000;
    tick();

    // Pointer wrap (ptr=2) and withdrawal
    set_lane(3, 8'h0F, 8'hFF, 2'b10);
    set_lane(1, 8'h12, 8'h34, 2'b01);
    req_valid = 4'b1010;
    #1;
    check_val("wrap_ready3", 32'(req_ready), 32'b1000);
    tick();
    check_val("wrap_id3", 32'(rsp_id), 32'd3);
    check_val("wrap_y3",  32'(rsp_y),  32'hF0);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    check_val("hold_ready", 32'(req_ready), 32'd0);
    tick();
    check_val("hold_id", 32'(rsp_id), 32'd3);
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    tick();
    check_val("wd_drain", 32'(rsp_valid), 32'd0);
    req_valid = 4'b1111;
    #1;
    check_val("wd_ptr_kept", 32'(req_ready), 32'b0001);
    req_valid = 4'b0010;
    #1;
    check_val("wrap_ready1", 32'(req_ready), 32'b0010);
    tick();
    check_val("wrap_id1",    32'(rsp_id),    32'd1);
    check_val("wrap_y1",     32'(rsp_y),     32'h36);
    check_val("wrap_valid1", 32'(rsp_valid), 32'd1);

    // Reset mid-stream, no clock edge needed
    rst_n = 1'b0;
    #1;
    check_val("mrst_valid", 32'(rsp_valid), 32'd0);
    check_val("mrst_y",     32'(rsp_y),     32'd0);
    check_val("mrst_id",    32'(rsp_id),    32'd0);
    check_val("mrst_ready", 32'(req_ready), 32'd0);
`ifdef GATE_GRANT_CNT_EN
    check_val("mrst_cnt",   32'(grant_cnt), 32'd0);
`endif
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    req_valid = 4'b0000;
    check_val("post_id",    32'(rsp_id),    32'd1);
    check_val("post_valid", 32'(rsp_valid), 32'd1);
`ifdef GATE_GRANT_CNT_EN
    check_val("cnt_five",   32'(grant_cnt), 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
